// File: rtl/ar_br_cr_seq_unit.sv
// ar_br_cr_seq_unit: sequential AR/BR/CR shift datapath with its control FSM; ARBRCR_SAT_EN enables saturating left shifts
module ar_br_cr_seq_unit #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               reset_b,
  input  logic               start,
  input  logic [WIDTH-1:0]   ar_data,
  input  logic [WIDTH-1:0]   br_data,
  input  logic [SHAMT_W-1:0] shift_amt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   cr_data,
  output logic               ar_neg,
  output logic               ar_pos,
  output logic               ar_zero,
  output logic               overflow
);
  typedef enum logic [1:0] {IDLE, EVAL, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] ar_q, ar_d, br_q, br_d, cr_q, cr_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic mul_q, mul_d, ovf_q, ovf_d;
  logic sign_flip;
  assign sign_flip = cr_q[WIDTH-1] ^ cr_q[WIDTH-2];
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign cr_data   = cr_q;
  assign overflow  = ovf_q;
  assign ar_zero   = ar_q == '0;
  assign ar_neg    = ar_q[WIDTH-1];
  assign ar_pos    = ~ar_q[WIDTH-1] & ~ar_zero;
  // state and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= IDLE;
      ar_q    <= '0;
      br_q    <= '0;
      cr_q    <= '0;
      cnt_q   <= '0;
      mul_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ar_q    <= ar_d;
      br_q    <= br_d;
      cr_q    <= cr_d;
      cnt_q   <= cnt_d;
      mul_q   <= mul_d;
      ovf_q   <= ovf_d;
    end
  end
  // next-state and datapath update; a set overflow during MUL also marks CR as clamped in the saturating build
  always_comb begin
    state_d = state_q;
    ar_d    = ar_q;
    br_d    = br_q;
    cr_d    = cr_q;
    cnt_d   = cnt_q;
    mul_d   = mul_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (start) begin
        ar_d    = ar_data;
        br_d    = br_data;
        cnt_d   = shift_amt;
        ovf_d   = 1'b0;
        state_d = EVAL;
      end
      EVAL: begin
        mul_d   = ~ar_q[WIDTH-1];
        cr_d    = ar_zero ? '0 : ar_neg ? ar_q : br_q;
        state_d = (ar_zero || cnt_q == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        cnt_d   = cnt_q - SHAMT_W'(1);
        state_d = cnt_q == SHAMT_W'(1) ? DONE : SHIFT;
        if (mul_q) begin
          ovf_d = ovf_q | sign_flip;
`ifdef ARBRCR_SAT_EN
          cr_d  = ovf_q ? cr_q :
                  sign_flip ? {cr_q[WIDTH-1], {(WIDTH-1){~cr_q[WIDTH-1]}}} :
                  {cr_q[WIDTH-2:0], 1'b0};
`else
          cr_d  = {cr_q[WIDTH-2:0], 1'b0};
`endif
        end else begin
          cr_d  = {cr_q[WIDTH-1], cr_q[WIDTH-1:1]};
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: doc/ar_br_cr_seq_unit.md
Name: ar_br_cr_seq_unit

Overview:
Parametrised sequential successor of the AR/BR/CR datapath, with the datapath and its control FSM in one block.
- Loads AR and BR on a start handshake.
- Classifies AR as negative, positive or zero.
- Builds CR over N cycles:
  - AR negative: arithmetic shift-right of AR (divide by 2^N).
  - AR positive: shift-left of BR (multiply by 2^N), with signed overflow detection.
  - AR zero: clear.
- Reports completion with busy/done.

Parameters:
WIDTH, 16, data width of AR/BR/CR; WIDTH >= 2.
SHAMT_W, 4, width of shift_amt; max shift count is 2^SHAMT_W - 1.

Ports:
clk  in  1  system clock, rising edge.
reset_b  in  1  asynchronous, active-low reset.
start  in  1  request; sampled only in IDLE.
ar_data  in  WIDTH  AR operand, captured with start.
br_data  in  WIDTH  BR operand, captured with start.
shift_amt  in  SHAMT_W  shift count N, captured with start.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle completion pulse.
cr_data  out  WIDTH  CR register (two's complement).
ar_neg  out  1  stored AR[WIDTH-1].
ar_pos  out  1  stored AR non-negative and non-zero.
ar_zero  out  1  stored AR == 0.
overflow  out  1  sticky signed overflow from left shifts.

Behaviour:
Reset and register rules:
- Reset (reset_b=0, async) forces:
  - state IDLE;
  - AR, BR, CR and count to 0;
  - busy=0, done=0, overflow=0;
  - therefore ar_zero=1, ar_neg=0, ar_pos=0.
- Reset mid-operation aborts it. No done pulse is issued.
- Flags are combinational from the stored AR register, not from ar_data.
- All registers update only on clk rising edge (except async reset).

FSM states: IDLE, EVAL, SHIFT, DONE.
- IDLE:
  - start=1 at an edge: capture AR<=ar_data, BR<=br_data, count<=shift_amt; clear overflow; go EVAL.
  - start=0: stay.
- EVAL (1 cycle):
  - AR negative: CR<=AR, mode=DIV.
  - AR positive: CR<=BR, mode=MUL.
  - AR zero: CR<=0, go DONE.
  - Non-zero AR with count==0: go DONE (CR unshifted).
  - Otherwise: go SHIFT.
- SHIFT (one shift per cycle):
  - DIV: CR<={CR[W-1],CR[W-1:1]}.
  - MUL: CR<=CR<<1, zero-fill. If CR[W-1]!=CR[W-2] before the shift, set overflow (sticky until next capture).
  - count decrements each cycle. The shift performed with count==1 is the last; the next state is DONE.
- DONE (1 cycle):
  - done=1, busy=1.
  - Next state IDLE. start is not sampled in DONE.

Handshake:
- start is ignored while busy=1; nothing is queued.
- start held high across DONE→IDLE is accepted at the first IDLE edge. Back-to-back operations therefore have a one-cycle gap.

Holding:
- cr_data holds its value from DONE until the next EVAL.
- AR and BR hold until the next capture.

Latency (capture edge = edge 1):
- done is high in the cycle after edge N+2 for non-zero AR with N>=1.
- done is high in the cycle after edge 2 for AR==0 or N==0.

Optional Feature:
Macro ARBRCR_SAT_EN.
- Defined: on the MUL shift that sets overflow, CR is clamped instead of shifted:
  - to {0,{W-1{1}}} if the pre-shift sign is 0;
  - to {1,{W-1{0}}} if it is 1.
  - Remaining shifts hold the clamped value; count still runs to completion.
- Undefined: CR wraps (plain shift); overflow still flags.
- DIV behaviour is identical in both builds.

Test Plan:
1. WIDTH=16. Reset, then start with ar=0xFFF0, br=0x1111, N=2.
   → ar_neg=1; CR=0xFFF0 after edge 2, 0xFFF8 after edge 3, 0xFFFC after edge 4; done pulse in the cycle after edge 4; overflow=0.
2. ar=0x0005, br=0x1234, N=3.
   → CR sequence 0x2468, 0x48D0, then 0x91A0 with overflow=1 (no SAT); with ARBRCR_SAT_EN, final CR=0x7FFF and overflow=1; done after edge 5.
3. ar=0x0000, br=0x7777, N=5.
   → ar_zero=1; CR=0x0000; done in the cycle after edge 2; no SHIFT cycles.
4. ar=0x8000, N=0.
   → CR=0x8000; done after edge 2; then ar=0x0001, br=0x0003, N=1 → CR=0x0006, overflow=0 (sticky flag cleared at capture).
5. start pulses during SHIFT of a N=4 run → ignored, single done pulse, busy high for exactly 6 cycles. Second run: ar=0x0001, br=0x0001, N=4; assert reset_b=0 mid-SHIFT → immediately state IDLE, cr_data=0, busy=0, no done; ar_zero=1.
